tff_array: RTL and testbench

Parametrised bank of WIDTH synchronous toggle flip-flops with a shared mode control. Each bit toggles independently, or the bits are cascaded as a T-flip-flop up/down counter, or they are parallel-loaded. The block replaces single-bit toggle flops wherever the design needs multi-bit toggle state, frequency division or event counting. It drives registered terminal-count and sticky overflow flags for downstream control logic.

---
 rtl/tff_array.sv | 50 +++++
 tb/tb_tff_array.sv | 95 +++++++++
 2 files changed

// File: rtl/tff_array.sv
// tff_array: bank of toggle flip-flops with independent toggle, cascaded up/down count and parallel load
module tff_array #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);
  logic [WIDTH-1:0] q_q, q_d, up_t, dn_t;
  logic tc_q, tc_d, ovf_q, ovf_d;
  // cascaded toggle enables: a bit flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q_q[i-1];
      dn_t[i] = dn_t[i-1] & ~q_q[i-1];
    end
  end
  always_comb begin
    q_d = !en ? q_q :
          mode == 2'b00 ? q_q ^ t :
          mode == 2'b01 ? q_q ^ up_t :
          mode == 2'b10 ? q_q ^ dn_t : d;
    tc_d = en & ((mode == 2'b01 & (&q_q)) | (mode == 2'b10 & ~(|q_q)));
    ovf_d = tc_d | (ovf_q & ~clr_ovf);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VAL;
      tc_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q <= q_d;
      tc_q <= tc_d;
      ovf_q <= ovf_d;
    end
  end
  assign q = q_q;
  assign tc = tc_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_tff_array.sv
// tb_tff_array: directed vectors with a scoreboard queue checked by an independent monitor
module tb_tff_array;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, clr_ovf = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] t = '0, d = '0, q;
  logic tc, ovf;
  typedef struct {
    int id;
    logic [7:0] q;
    logic tc;
    logic ovf;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  tff_array #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .clr_ovf(clr_ovf), .q(q), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step(input int id, input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] tv, input logic [7:0] dv, input logic c,
                      input logic [7:0] eq, input logic etc, input logic eovf);
    @(negedge clk);
    rst = r; en = e; mode = m; t = tv; d = dv; clr_ovf = c;
    sb.push_back('{id, eq, etc, eovf});
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_cmp++;
        if (q !== x.q || tc !== x.tc || ovf !== x.ovf) begin
          n_err++;
          $display("FAIL step%0d: got q=%h tc=%b ovf=%b, want q=%h tc=%b ovf=%b",
                   x.id, q, tc, ovf, x.q, x.tc, x.ovf);
        end
      end
    end
  end

  initial begin : stim
    //        id rst en mode   t      d      clr   q      tc    ovf
    step( 1, 1, 1, 2'b01, 8'h00, 8'h00, 0, 8'hA5, 0, 0);
    step( 2, 0, 0, 2'b01, 8'h00, 8'h00, 0, 8'hA5, 0, 0);
    step( 3, 0, 1, 2'b11, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    step( 4, 0, 1, 2'b00, 8'h0F, 8'hFF, 0, 8'h0F, 0, 0);
    step( 5, 0, 1, 2'b00, 8'h0F, 8'hFF, 0, 8'h00, 0, 0);
    step( 6, 0, 1, 2'b00, 8'h0F, 8'hFF, 0, 8'h0F, 0, 0);
    step( 7, 0, 1, 2'b00, 8'h00, 8'hFF, 0, 8'h0F, 0, 0);
    step( 8, 0, 1, 2'b11, 8'hFF, 8'hFE, 0, 8'hFE, 0, 0);
    step( 9, 0, 1, 2'b01, 8'hFF, 8'h00, 0, 8'hFF, 0, 0);
    step(10, 0, 1, 2'b01, 8'hFF, 8'h00, 0, 8'h00, 1, 1);
    step(11, 0, 1, 2'b01, 8'hFF, 8'h00, 0, 8'h01, 0, 1);
    step(12, 0, 1, 2'b11, 8'h00, 8'h01, 0, 8'h01, 0, 1);
    step(13, 0, 1, 2'b10, 8'hFF, 8'h77, 0, 8'h00, 0, 1);
    step(14, 0, 1, 2'b10, 8'hFF, 8'h77, 0, 8'hFF, 1, 1);
    step(15, 0, 0, 2'b10, 8'h00, 8'h00, 1, 8'hFF, 0, 0);
    step(16, 0, 1, 2'b01, 8'h00, 8'h00, 1, 8'h00, 1, 1);
    step(17, 0, 1, 2'b11, 8'h00, 8'hFF, 1, 8'hFF, 0, 0);
    step(18, 0, 0, 2'b01, 8'h00, 8'h00, 0, 8'hFF, 0, 0);
    step(19, 0, 1, 2'b01, 8'h00, 8'h00, 0, 8'h00, 1, 1);
    step(20, 0, 0, 2'b01, 8'h00, 8'h00, 0, 8'h00, 0, 1);
    step(21, 0, 1, 2'b11, 8'h00, 8'h10, 1, 8'h10, 0, 0);
    step(22, 0, 1, 2'b01, 8'h00, 8'h00, 0, 8'h11, 0, 0);
    step(23, 0, 0, 2'b01, 8'h00, 8'h00, 0, 8'h11, 0, 0);
    step(24, 0, 1, 2'b01, 8'h00, 8'h00, 0, 8'h12, 0, 0);
    step(25, 0, 0, 2'b01, 8'h00, 8'h00, 0, 8'h12, 0, 0);
    step(26, 0, 1, 2'b01, 8'h00, 8'h00, 0, 8'h13, 0, 0);
    step(27, 1, 1, 2'b01, 8'h00, 8'h00, 0, 8'hA5, 0, 0);
    step(28, 0, 1, 2'b01, 8'h00, 8'h00, 0, 8'hA6, 0, 0);
    step(29, 0, 1, 2'b00, 8'hA5, 8'h00, 0, 8'h03, 0, 0);
    step(30, 0, 1, 2'b10, 8'h00, 8'h00, 0, 8'h02, 0, 0);
    step(31, 0, 1, 2'b11, 8'h00, 8'h80, 0, 8'h80, 0, 0);
    step(32, 0, 1, 2'b10, 8'h00, 8'h00, 0, 8'h7F, 0, 0);
    step(33, 0, 1, 2'b01, 8'h00, 8'h00, 0, 8'h80, 0, 0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
